// File: rtl/timebase_sched.sv
// timebase_sched: NCH run-time programmable single-cycle tick enables on one clock.
// Define TIMEBASE_SQ_EN to build the per-channel square-wave outputs; otherwise sq is tied low.
module timebase_sched #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 27,
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic           cfg_oneshot,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] stop,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done,
  output logic [NCH-1:0] sq
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e         state_q [NCH];
  state_e         state_d [NCH];
  logic [CW-1:0]  count_q [NCH];
  logic [CW-1:0]  count_d [NCH];
  logic [CW-1:0]  div_q   [NCH];
  logic [CW-1:0]  div_d   [NCH];
  logic [CW-1:0]  sdiv_q  [NCH];
  logic [CW-1:0]  sdiv_d  [NCH];
  logic [NCH-1:0] mode_q, mode_d, smode_q, smode_d, pending_q, pending_d;
  logic [NCH-1:0] tick_q, tick_d, done_q, done_d;
  logic [NCH-1:0] acc, wrap, leave;
  logic           accept;

  always_comb begin
    cfg_ready = 1'b1;
    if (32'(cfg_ch) < NCH) cfg_ready = ~pending_q[cfg_ch];
  end

  assign accept = cfg_valid & cfg_ready;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      state_d[c]   = state_q[c];
      count_d[c]   = count_q[c];
      div_d[c]     = div_q[c];
      sdiv_d[c]    = sdiv_q[c];
      mode_d[c]    = mode_q[c];
      smode_d[c]   = smode_q[c];
      pending_d[c] = pending_q[c];
      tick_d[c]    = 1'b0;
      done_d[c]    = 1'b0;
      acc[c]       = accept && (cfg_ch == CHW'(c));
      wrap[c]      = (count_q[c] == div_q[c] - CW'(1));
      // done_q marks the cycle after a one-shot tick: the channel retires at this edge
      leave[c]     = (state_q[c] == StRun) && (stop[c] || done_q[c]);

      if (state_q[c] == StIdle) begin
        if (start[c] && !stop[c] && (div_q[c] != '0)) begin
          state_d[c] = StRun;
          count_d[c] = '0;
        end
        if (acc[c]) begin
          div_d[c]  = cfg_div;
          mode_d[c] = cfg_oneshot;
        end
      end else if (leave[c]) begin
        state_d[c] = StIdle;
        count_d[c] = '0;
        if (pending_q[c]) begin
          div_d[c]     = sdiv_q[c];
          mode_d[c]    = smode_q[c];
          pending_d[c] = 1'b0;
        end
        if (acc[c]) begin
          div_d[c]  = cfg_div;
          mode_d[c] = cfg_oneshot;
        end
      end else if (acc[c] && (cfg_div == '0)) begin
        state_d[c] = StIdle;
        count_d[c] = '0;
        div_d[c]   = '0;
        mode_d[c]  = cfg_oneshot;
      end else begin
        count_d[c] = wrap[c] ? '0 : count_q[c] + CW'(1);
        tick_d[c]  = wrap[c];
        done_d[c]  = wrap[c] & mode_q[c];
        // The shadow takes effect only once the running period has finished
        if (wrap[c] && pending_q[c]) begin
          div_d[c]     = sdiv_q[c];
          mode_d[c]    = smode_q[c];
          pending_d[c] = 1'b0;
        end
        if (acc[c]) begin
          sdiv_d[c]    = cfg_div;
          smode_d[c]   = cfg_oneshot;
          pending_d[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= StIdle;
        count_q[c] <= '0;
        div_q[c]   <= '0;
        sdiv_q[c]  <= '0;
      end
      mode_q    <= '0;
      smode_q   <= '0;
      pending_q <= '0;
      tick_q    <= '0;
      done_q    <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
        count_q[c] <= count_d[c];
        div_q[c]   <= div_d[c];
        sdiv_q[c]  <= sdiv_d[c];
      end
      mode_q    <= mode_d;
      smode_q   <= smode_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) busy[c] = (state_q[c] == StRun);
  end

  assign tick = tick_q;
  assign done = done_q;

`ifdef TIMEBASE_SQ_EN
  logic [NCH-1:0] sq_q, sq_d;

  // Computed from next-state values so sq lines up with the registered count
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      sq_d[c] = (state_d[c] == StRun) && (count_d[c] >= (div_d[c] >> 1));
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) sq_q <= '0;
    else       sq_q <= sq_d;
  end

  assign sq = sq_q;
`else
  assign sq = '0;
`endif

endmodule

// File: tb/tb_timebase_sched.sv
// tb_timebase_sched: directed scenarios plus random traffic checked every cycle against
// a per-channel behavioural model (elapsed-cycles-in-period formulation).
module tb_timebase_sched;

  localparam int NCH = 4;
  localparam int CW  = 27;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_oneshot;
  logic [NCH-1:0] start, stop, tick, busy, done, sq;

  always #5 clk = ~clk;

  timebase_sched #(.NCH(NCH), .CW(CW)) dut (
    .Clk(clk), .Reset(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop),
    .tick(tick), .busy(busy), .done(done), .sq(sq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: run flag, cycles elapsed in the current period, live and shadow config
  bit m_run [NCH];
  int m_ph  [NCH];
  int m_dv  [NCH];
  int m_sdv [NCH];
  bit m_om  [NCH];
  bit m_som [NCH];
  bit m_pend[NCH];
  bit m_exit[NCH];
  logic [NCH-1:0] e_tick, e_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [NCH-1:0] exp_busy();
    for (int c = 0; c < NCH; c++) exp_busy[c] = m_run[c];
  endfunction

  function automatic logic [NCH-1:0] exp_sq();
    exp_sq = '0;
`ifdef TIMEBASE_SQ_EN
    for (int c = 0; c < NCH; c++) exp_sq[c] = m_run[c] && (m_ph[c] >= m_dv[c] / 2);
`endif
  endfunction

  task automatic model_step();
    bit ok;
    ok = cfg_valid && !m_pend[cfg_ch];
    e_tick = '0;
    e_done = '0;
    for (int c = 0; c < NCH; c++) begin
      bit a;
      bit nd;
      a  = ok && (int'(cfg_ch) == c);
      nd = 1'b0;
      if (rst) begin
        m_run[c] = 0; m_ph[c] = 0; m_dv[c] = 0; m_sdv[c] = 0;
        m_om[c] = 0; m_som[c] = 0; m_pend[c] = 0;
      end else if (!m_run[c]) begin
        if (start[c] && !stop[c] && m_dv[c] != 0) begin
          m_run[c] = 1; m_ph[c] = 0;
        end
        if (a) begin m_dv[c] = int'(cfg_div); m_om[c] = cfg_oneshot; end
      end else if (stop[c] || m_exit[c]) begin
        m_run[c] = 0; m_ph[c] = 0;
        if (m_pend[c]) begin m_dv[c] = m_sdv[c]; m_om[c] = m_som[c]; m_pend[c] = 0; end
        if (a) begin m_dv[c] = int'(cfg_div); m_om[c] = cfg_oneshot; end
      end else if (a && cfg_div == 0) begin
        m_run[c] = 0; m_ph[c] = 0; m_dv[c] = 0; m_om[c] = cfg_oneshot;
      end else begin
        m_ph[c]++;
        if (m_ph[c] == m_dv[c]) begin
          e_tick[c] = 1'b1;
          nd = m_om[c];
          m_ph[c] = 0;
          if (m_pend[c]) begin m_dv[c] = m_sdv[c]; m_om[c] = m_som[c]; m_pend[c] = 0; end
        end
        if (a) begin m_sdv[c] = int'(cfg_div); m_som[c] = cfg_oneshot; m_pend[c] = 1; end
      end
      e_done[c] = nd;
      m_exit[c] = nd;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("cfg_ready", cfg_ready, !m_pend[cfg_ch]);
    @(posedge clk);
    model_step();
    #1;
    chk("tick", tick, e_tick);
    chk("busy", busy, exp_busy());
    chk("done", done, e_done);
    chk("sq", sq, exp_sq());
  endtask

  task automatic clr();
    rst = 0; cfg_valid = 0; start = '0; stop = '0;
  endtask

  task automatic do_cfg(input int ch, input int dv, input bit os);
    cfg_valid = 1; cfg_ch = 2'(ch); cfg_div = CW'(dv); cfg_oneshot = os;
    cycle();
    cfg_valid = 0;
  endtask

  initial begin
    int cnt, cnt2, first, second;
    logic [31:0] pat;
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 0; m_ph[c] = 0; m_dv[c] = 0; m_sdv[c] = 0;
      m_om[c] = 0; m_som[c] = 0; m_pend[c] = 0; m_exit[c] = 0;
    end
    e_tick = '0; e_done = '0;
    clr();
    cfg_ch = 0; cfg_div = '0; cfg_oneshot = 0;

    // T1 reset
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    chk("t1_tick", tick, 0);
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 0);
    chk("t1_sq", sq, 0);
    chk("t1_ready", cfg_ready, 1);

    // T2 periodic div=4
    do_cfg(0, 4, 0);
    start[0] = 1; cycle(); start[0] = 0;
    chk("t2_busy_t1", busy[0], 1);
    cnt = 0; first = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (tick[0]) begin cnt++; if (first == 0) first = i; end
    end
    chk("t2_first_tick", first, 4);
    chk("t2_tick_count", cnt, 3);
    stop[0] = 1; cycle(); stop[0] = 0;
    chk("t2_stop_busy", busy[0], 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin cycle(); if (tick[0]) cnt++; end
    chk("t2_no_tick_after_stop", cnt, 0);

    // T3 one-shot div=3
    do_cfg(1, 3, 1);
    start[1] = 1; cycle(); start[1] = 0;
    cnt = 0; cnt2 = 0; first = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (tick[1]) begin cnt++; if (first == 0) first = i; end
      if (done[1]) begin
        cnt2++;
        chk("t3_done_with_tick", tick[1], 1);
      end
    end
    chk("t3_first_tick", first, 3);
    chk("t3_tick_count", cnt, 1);
    chk("t3_done_count", cnt2, 1);
    chk("t3_busy_after", busy[1], 0);

    // T4 reconfigure running channel: div 5 -> 2 mid-period
    do_cfg(0, 5, 0);
    start[0] = 1; cycle(); start[0] = 0;
    for (int i = 0; i < 7; i++) cycle();
    do_cfg(0, 2, 0);
    chk("t4_ready_low", cfg_ready, 0);
    first = 0; second = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (tick[0]) begin
        if (first == 0) first = i;
        else if (second == 0) second = i;
      end
    end
    chk("t4_last_old_tick", first, 2);
    chk("t4_first_new_tick", second, 4);
    chk("t4_ready_high", cfg_ready, 1);
    stop[0] = 1; cycle(); stop[0] = 0;

    // T5 conflicts
    do_cfg(2, 3, 0);
    start[2] = 1; stop[2] = 1; cycle(); clr();
    chk("t5_start_stop_idle", busy[2], 0);
    start[2] = 1; cycle(); start[2] = 0;
    cycle();
    do_cfg(2, 0, 0);
    chk("t5_div0_idle", busy[2], 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin cycle(); if (tick[2] || done[2]) cnt++; end
    chk("t5_div0_no_tick", cnt, 0);
    start[3] = 1; cycle(); start[3] = 0;
    chk("t5_start_div0", busy[3], 0);

    // T6 square wave patterns
    do_cfg(0, 4, 0);
    start[0] = 1; cycle(); start[0] = 0;
    pat = {31'd0, sq[0]};
    for (int i = 1; i < 8; i++) begin cycle(); pat = {pat[30:0], sq[0]}; end
`ifdef TIMEBASE_SQ_EN
    chk("t6_sq_div4", pat, 32'h33);
`else
    chk("t6_sq_div4", pat, 32'h0);
`endif
    stop[0] = 1; cycle(); stop[0] = 0;
    do_cfg(0, 5, 0);
    start[0] = 1; cycle(); start[0] = 0;
    pat = {31'd0, sq[0]};
    for (int i = 1; i < 10; i++) begin cycle(); pat = {pat[30:0], sq[0]}; end
`ifdef TIMEBASE_SQ_EN
    chk("t6_sq_div5", pat, 32'h0E7);
`else
    chk("t6_sq_div5", pat, 32'h0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NCH; c++) begin
        start[c] = ($urandom_range(0, 7) == 0);
        stop[c]  = ($urandom_range(0, 39) == 0);
      end
      cfg_valid   = ($urandom_range(0, 5) == 0);
      cfg_ch      = 2'($urandom_range(0, NCH - 1));
      cfg_div     = ($urandom_range(0, 9) == 0) ? '0 : CW'($urandom_range(1, 7));
      cfg_oneshot = 1'($urandom_range(0, 1));
      cycle();
    end
    clr();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
